alu_uart_if: RTL and testbench
==============================

# alu_uart_if

Byte-serial front end for the `alu` block. It takes received bytes from the UART receiver and loads them in order into the ALU operand and opcode registers (A, then B, then OP). It samples the combinational ALU result and hands it to the UART transmitter as a single byte. It sits between `uart_rx`/`uart_tx` and `alu`, and drives `dato_a`, `dato_b` and `op` directly.

## Interface
- `NB_DATA`, 8: operand/result width in bits.
- `NB_OP`, 8: opcode width in bits.

- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in NB_DATA: byte from the UART receiver, valid when `rx_done`=1.
- `rx_done` in 1: one-cycle strobe, one received byte.
- `tx_busy` in 1: transmitter busy; `tx_start` is never issued while high.
- `alu_res` in NB_DATA: `alu.res`, combinational from `dato_a`/`dato_b`/`op`.
- `dato_a` out NB_DATA: operand A register to the ALU, signed.
- `dato_b` out NB_DATA: operand B register to the ALU (also the shift amount).
- `op` out NB_OP: opcode register to the ALU.
- `tx_data` out NB_DATA: result byte to the transmitter, held until the next issue.
- `tx_start` out 1: one-cycle strobe to the transmitter.
- `overrun` out 1: sticky flag, a byte arrived while a result was pending.

## Operation
- FSM with 4 states: WAIT_A, WAIT_B, WAIT_OP, SEND. Reset state is WAIT_A.
- WAIT_A with `rx_done`: `dato_a` <= `rx_data`, go to WAIT_B.
- WAIT_B with `rx_done`: `dato_b` <= `rx_data`, go to WAIT_OP.
- WAIT_OP with `rx_done`: `op` <= `rx_data`, go to SEND.
- In any WAIT_* state without `rx_done`: hold state and all registers.
- SEND with `tx_busy`=0: `tx_data` <= `alu_res`, `tx_start` <= 1, go to WAIT_A.
- SEND with `tx_busy`=1: hold state, `tx_start`=0. No timeout; waits indefinitely.
- `rx_done` in SEND: byte discarded, `overrun` <= 1, state unaffected. `overrun` clears only on reset.
- `rx_done` and `tx_busy` falling in the same SEND cycle: the send is issued and the byte is flagged as overrun.
- Operand registers hold their last value across frames. A new A byte changes the ALU inputs immediately; this is harmless because the result is only sampled in SEND.
- Opcode values are passed through unchecked. Undefined opcodes yield whatever `alu` produces.
- No arithmetic in this block; all widths pass straight through.

## Timing
- Reset values: `dato_a`=0, `dato_b`=0, `op`=0, `tx_data`=0, `tx_start`=0, `overrun`=0, state WAIT_A.
- Assertion of `rst_n`=0 takes effect immediately, including mid-frame or mid-SEND. Any partial frame is lost and a pending send is not issued.
- All outputs are registered.
- Latency: edge E0 samples `rx_done` with the OP byte. At the earliest, `tx_start` is high for the cycle after E1, and `tx_data` is valid from that same cycle.
- `alu_res` is sampled at E1, one full cycle after `op` settles. `alu` must therefore meet single-cycle combinational timing.
- `tx_start` is high for exactly one cycle per frame, never two consecutive cycles.
- Back-to-back frames are accepted: the next A byte may arrive on the cycle right after `tx_start`.

## Structure
- Shared package `alu_pkg`:
  - opcode constants: ADD 8'h20, SUB 8'h22, AND 8'h24, OR 8'h25, XOR 8'h26, SRA 8'h03, SRL 8'h02, NOR 8'h27;
  - FSM state encoding (2-bit: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SEND=3);
  - `NB_DATA`/`NB_OP` defaults.
  - The `alu` block and its bench reuse these opcode constants.
- No sub-module. One FSM plus a register bank, single file. `alu` is instantiated by the top level, not inside this block.

## Test plan
All benches use a behavioural `alu` model, or the real `alu`.
- Bytes 0x05, 0x03, 0x20 with `tx_busy`=0 -> `dato_a`=0x05, `dato_b`=0x03, `op`=0x20; `tx_start` pulses once, exactly 2 cycles after the OP strobe; `tx_data`=0x08.
- Bytes 0x03, 0x05, 0x22 -> `tx_data`=0xFE. Bytes 0x80, 0x03, 0x03 (SRA) -> 0xF0. Bytes 0x80, 0x03, 0x02 (SRL) -> 0x10.
- `tx_busy` held high for 5 cycles after the OP strobe -> no `tx_start` during busy; a single pulse on the cycle after `tx_busy` falls; `tx_data` reflects `alu_res` at that point.
- Extra byte 0x55 sent while in SEND (`tx_busy`=1) -> `overrun`=1 and stays 1; the next frame still assembles correctly from its own A byte.
- Assert `rst_n` low after only the A and B bytes -> all outputs return to 0, state WAIT_A; the next 3 bytes form a fresh frame.
- Two frames back-to-back with no idle cycles -> two `tx_start` pulses with the correct results, in order; `overrun`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu block and its UART front end.
//   - default operand/opcode widths
//   - opcode constants understood by alu
//   - state encoding of the alu_uart_if frame assembler
package alu_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_OP_DEF   = 8;

  // Opcode constants (MIPS-style funct codes)
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_NOR = 8'h27;

  // Frame assembler states
  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_WAIT_OP = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

endpackage : alu_pkg

// File: rtl/alu_uart_if.sv
// Byte-serial front end for alu: assembles A, B, OP from received bytes,
// then samples the combinational alu result and hands it to the transmitter.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   rx_data, rx_done   received byte + one-cycle strobe
//   tx_busy            transmitter busy, blocks tx_start
//   alu_res            combinational alu result
//   dato_a, dato_b, op operand/opcode registers driving alu
//   tx_data, tx_start  result byte + one-cycle strobe to transmitter
//   overrun            sticky: byte arrived while a result was pending
module alu_uart_if
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               rx_done,
  input  logic               tx_busy,
  input  logic [NB_DATA-1:0] alu_res,
  output logic [NB_DATA-1:0] dato_a,
  output logic [NB_DATA-1:0] dato_b,
  output logic [NB_OP-1:0]   op,
  output logic [NB_DATA-1:0] tx_data,
  output logic               tx_start,
  output logic               overrun
);

  state_t             r_state;
  logic [NB_DATA-1:0] r_dato_a;
  logic [NB_DATA-1:0] r_dato_b;
  logic [NB_OP-1:0]   r_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               r_overrun;

  // Frame FSM and register bank; tx_start defaults low so it is a single pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_A;
      r_dato_a   <= '0;
      r_dato_b   <= '0;
      r_op       <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_WAIT_A: begin
          if (rx_done) begin
            r_dato_a <= rx_data;
            r_state  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (rx_done) begin
            r_dato_b <= rx_data;
            r_state  <= ST_WAIT_OP;
          end
        end
        ST_WAIT_OP: begin
          if (rx_done) begin
            r_op    <= NB_OP'(rx_data);
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A byte here is dropped; the send itself is unaffected
          if (rx_done) begin
            r_overrun <= 1'b1;
          end
          // alu_res has had a full cycle since op settled
          if (!tx_busy) begin
            r_tx_data  <= alu_res;
            r_tx_start <= 1'b1;
            r_state    <= ST_WAIT_A;
          end
        end
        default: r_state <= ST_WAIT_A;
      endcase
    end
  end

  assign dato_a   = r_dato_a;
  assign dato_b   = r_dato_b;
  assign op       = r_op;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign overrun  = r_overrun;

endmodule : alu_uart_if

// File: tb/tb_alu_uart_if.sv
// Randomized self-checking bench for alu_uart_if with a behavioural alu.
module tb_alu_uart_if;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic [7:0] alu_res;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [7:0] op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       overrun;

  int n_vec  = 0;
  int n_err  = 0;
  int pulses = 0;
  int exp_pulses = 0;
  bit exp_ovr = 1'b0;
  bit prev_start = 1'b0;

  always #5 clk = ~clk;

  alu_uart_if #(.NB_DATA(8), .NB_OP(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_busy  (tx_busy),
    .alu_res  (alu_res),
    .dato_a   (dato_a),
    .dato_b   (dato_b),
    .op       (op),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .overrun  (overrun)
  );

  // Behavioural alu: result of one operation on two bytes
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] o);
    int sa;
    case (o)
      OP_ADD: return 8'(a + b);
      OP_SUB: return 8'(a - b);
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_NOR: return ~(a | b);
      OP_SRL: return (b >= 8) ? 8'h00 : 8'(a >> b);
      OP_SRA: begin
        sa = int'($signed(a));
        return (b >= 8) ? {8{a[7]}} : 8'(sa >>> b);
      end
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_res = alu_ref(dato_a, dato_b, op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse monitor: count tx_start pulses, never two in a row
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      pulses++;
      check("start_consecutive", 32'(prev_start), 32'd0);
    end
    prev_start = tx_start;
  end

  // All driving happens on the falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One complete frame, optionally with busy stall and overrun bytes
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                          input int gap, input int busy, input bit ovr_mid, input bit ovr_fall);
    int lat;
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    tx_busy = (busy > 0);
    send_byte(o);
    check("dato_a", 32'(dato_a), 32'(a));
    check("dato_b", 32'(dato_b), 32'(b));
    check("op", 32'(op), 32'(o));
    for (int i = 0; i < busy; i++) begin
      check("start_while_busy", 32'(tx_start), 32'd0);
      if (ovr_mid && i == busy / 2) begin
        rx_data = 8'h55;
        rx_done = 1'b1;
        exp_ovr = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
    end
    tx_busy = 1'b0;
    if (ovr_fall) begin
      rx_data = 8'hAA;
      rx_done = 1'b1;
      exp_ovr = 1'b1;
    end
    lat = 0;
    while (!tx_start && lat < 20) begin
      @(negedge clk);
      rx_done = 1'b0;
      lat++;
    end
    rx_done = 1'b0;
    exp_pulses++;
    if (!tx_start) begin
      check("start_timeout", 32'd0, 32'd1);
    end else begin
      check("start_latency", 32'(lat), 32'd1);
      check("tx_data", 32'(tx_data), 32'(alu_ref(a, b, o)));
    end
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic check_all_zero();
    check("rst_dato_a", 32'(dato_a), 32'd0);
    check("rst_dato_b", 32'(dato_b), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
  endtask

  logic [7:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

  initial begin
    logic [7:0] ra, rb, ro;
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_busy = 1'b0;
    idle(2);
    check_all_zero();
    rst_n = 1'b1;
    idle(1);

    // Known vectors
    do_frame(8'h05, 8'h03, OP_ADD, 0, 0, 0, 0);
    check("vec_add", 32'(tx_data), 32'h08);
    do_frame(8'h03, 8'h05, OP_SUB, 1, 0, 0, 0);
    check("vec_sub", 32'(tx_data), 32'hFE);
    do_frame(8'h80, 8'h03, OP_SRA, 0, 0, 0, 0);
    check("vec_sra", 32'(tx_data), 32'hF0);
    do_frame(8'h80, 8'h03, OP_SRL, 2, 0, 0, 0);
    check("vec_srl", 32'(tx_data), 32'h10);

    // Back-to-back frames, next A byte right in the tx_start cycle
    do_frame(8'h11, 8'h22, OP_OR, 0, 0, 0, 0);
    do_frame(8'h0F, 8'hF0, OP_NOR, 0, 0, 0, 0);
    check("b2b_nor", 32'(tx_data), 32'h00);
    check("b2b_overrun", 32'(overrun), 32'd0);
    idle(1);

    // Busy stall, then busy stall with an extra byte
    do_frame(8'h21, 8'h12, OP_XOR, 0, 5, 0, 0);
    do_frame(8'h40, 8'h07, OP_AND, 0, 5, 1, 0);
    check("overrun_set", 32'(overrun), 32'd1);
    idle(3);
    do_frame(8'h09, 8'h04, OP_ADD, 0, 0, 0, 0);
    check("after_overrun", 32'(tx_data), 32'h0D);
    // Extra byte on the same cycle tx_busy falls
    do_frame(8'h33, 8'h01, OP_SUB, 0, 2, 0, 1);

    // Reset mid-frame after A and B
    idle(1);
    send_byte(8'h77);
    send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    check_all_zero();
    exp_ovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(8'h07, 8'h02, OP_SUB, 0, 0, 0, 0);
    check("fresh_frame", 32'(tx_data), 32'h05);

    // Reset while a send is pending: nothing is issued
    tx_busy = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(OP_ADD);
    idle(2);
    rst_n = 1'b0;
    #1;
    check_all_zero();
    @(negedge clk);
    tx_busy = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("no_send_after_rst", 32'(tx_start), 32'd0);
      @(negedge clk);
    end

    // Randomized frames
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      ro = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
      do_frame(ra, rb, ro, $urandom_range(0, 2), $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("pulse_count", 32'(pulses), 32'(exp_pulses));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_uart_if
